// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op encodings (MULT, MULTU, DIV, DIVU)
//   - sequencer state encoding (IDLE, CALC, FIX)
//   - divide-by-zero LO value and small op-decode helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    // LO value committed by a divide with a zero divisor
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = {MDU_WIDTH{1'b1}};

    function automatic logic mdu_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic mdu_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// -----------------------------------------------------------------------------
// mdu_sequencer_if
// Core-side bundle of the multiply/divide unit.
//   core -> mdu : start, op, rs_val, rt_val, hi_we, lo_we, wdata, hi_re, lo_re
//   mdu -> core : hi, lo, busy, stall, done, div_zero
// Modports: master (core side), slave (mdu side).
// -----------------------------------------------------------------------------
interface mdu_sequencer_if #(parameter int WIDTH = 32) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             hi_re;
    logic             lo_re;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, rs_val, rt_val, hi_we, lo_we, wdata, hi_re, lo_re,
        input  hi, lo, busy, stall, done, div_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_we, lo_we, wdata, hi_re, lo_re,
        output hi, lo, busy, stall, done, div_zero
    );

endinterface

// File: rtl/mdu_datapath.sv
// -----------------------------------------------------------------------------
// mdu_datapath
// Accumulator / remainder datapath of the multiply/divide unit: operand
// magnitude capture, shift-add multiply step, restoring divide step and the
// final sign fix-up.
//   load_i      capture operands (issue edge)
//   step_i      perform one iteration (CALC)
//   dz_i        current op is a divide by zero (selects the DIV0 result)
//   op_i        op at issue; rs_val_i / rt_val_i operands at issue
//   dz_o        issuing op is a divide with zero divisor
//   res_hi_o/res_lo_o  fixed-up result, valid in FIX
// Optional (MDU_EARLY_TERM_EN): cnt_i iteration index, early_o multiply may
// finish in the current step.
// -----------------------------------------------------------------------------
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 dz_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     rs_val_i,
    input  logic [WIDTH-1:0]     rt_val_i,
`ifdef MDU_EARLY_TERM_EN
    input  logic [$clog2(WIDTH):0] cnt_i,
    output logic                 early_o,
`endif
    output logic                 dz_o,
    output logic [WIDTH-1:0]     res_hi_o,
    output logic [WIDTH-1:0]     res_lo_o
);

    logic [2*WIDTH-1:0] acc_q;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               sa_q;
    logic               sb_q;

    logic               is_div_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH-1:0]   acc_hi_s;
    logic [WIDTH-1:0]   acc_lo_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] step_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign is_div_s = mdu_is_div(op_i);
    assign a_neg_s  = mdu_is_signed(op_i) & rs_val_i[WIDTH-1];
    assign b_neg_s  = mdu_is_signed(op_i) & rt_val_i[WIDTH-1];
    assign mag_a_s  = a_neg_s ? (-rs_val_i) : rs_val_i;
    assign mag_b_s  = b_neg_s ? (-rt_val_i) : rt_val_i;
    assign dz_o     = is_div_s && (rt_val_i == {WIDTH{1'b0}});
    assign acc_hi_s = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo_s = acc_q[WIDTH-1:0];

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        if (acc_q[0]) begin
            sum_s = {1'b0, acc_hi_s} + {1'b0, m_q};
        end else begin
            sum_s = {1'b0, acc_hi_s};
        end
        // carry lands in the MSB as the accumulator shifts right
        mul_next_s = {sum_s, acc_lo_s[WIDTH-1:1]};

        rem_sh_s = acc_q[2*WIDTH-1:WIDTH-1];
        diff_s   = rem_sh_s - {1'b0, m_q};
        if (diff_s[WIDTH]) begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {diff_s[WIDTH-1:0], acc_lo_s[WIDTH-2:0], 1'b1};
        end
    end

`ifdef MDU_EARLY_TERM_EN
    logic [WIDTH-1:0]      mul_left_s;
    logic [$clog2(WIDTH):0] skip_s;

    // Multiply finishes now when no multiplier bits above the current one remain
    always_comb begin
        mul_left_s = acc_lo_s & ({WIDTH{1'b1}} >> cnt_i);
        skip_s     = ($clog2(WIDTH)+1)'(WIDTH-1) - cnt_i;
        if (!is_div_q && ((mul_left_s >> 1) == {WIDTH{1'b0}})) begin
            early_o     = 1'b1;
            step_next_s = mul_next_s >> skip_s;
        end else begin
            early_o     = 1'b0;
            step_next_s = is_div_q ? div_next_s : mul_next_s;
        end
    end
`else
    assign step_next_s = is_div_q ? div_next_s : mul_next_s;
`endif

    // Sign fix-up and result selection for the commit edge
    always_comb begin
        prod_fix_s = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
        quo_fix_s  = (sa_q ^ sb_q) ? (-acc_lo_s) : acc_lo_s;
        rem_fix_s  = sa_q ? (-acc_hi_s) : acc_hi_s;
        if (dz_i) begin
            // raw dividend was parked in the low half at issue
            res_hi_o = acc_lo_s;
            res_lo_o = DIV0_LO;
        end else if (is_div_q) begin
            res_hi_o = rem_fix_s;
            res_lo_o = quo_fix_s;
        end else begin
            res_hi_o = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_o = prod_fix_s[WIDTH-1:0];
        end
    end

    // Operand capture on issue, iteration update in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            m_q      <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
        end else if (load_i) begin
            is_div_q <= is_div_s;
            sa_q     <= a_neg_s;
            sb_q     <= b_neg_s;
            m_q      <= is_div_s ? mag_b_s : mag_a_s;
            acc_q    <= {{WIDTH{1'b0}},
                         dz_o ? rs_val_i : (is_div_s ? mag_a_s : mag_b_s)};
        end else if (step_i) begin
            acc_q    <= step_next_s;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Iterative multiply/divide unit owning the HI/LO pair. Sequencing FSM
// (IDLE -> CALC x WIDTH -> FIX), iteration counter, HI/LO registers, MTHI/MTLO
// and stall generation; arithmetic lives in mdu_datapath.
//   clk, rst_n   clock, async active-low reset (aborts any operation)
//   bus          mdu_sequencer_if.slave: issue/operands, MTHI/MTLO, MFHI/MFLO
//                decode hints, hi/lo/busy/done/div_zero (registered) and
//                stall (combinational)
// Optional feature macro: MDU_EARLY_TERM_EN (multiply early termination).
// -----------------------------------------------------------------------------
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic             load_s;
    logic             step_s;
    logic             dz_s;
    logic             last_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    assign load_s = (state_q == IDLE) && bus.start;
    assign step_s = (state_q == CALC);

`ifdef MDU_EARLY_TERM_EN
    logic early_s;
    assign last_s = (cnt_q == CNT_W'(WIDTH-1)) || early_s;
`else
    assign last_s = (cnt_q == CNT_W'(WIDTH-1));
`endif

    mdu_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_s),
        .step_i   (step_s),
        .dz_i     (div_zero_q),
        .op_i     (bus.op),
        .rs_val_i (bus.rs_val),
        .rt_val_i (bus.rt_val),
`ifdef MDU_EARLY_TERM_EN
        .cnt_i    (cnt_q),
        .early_o  (early_s),
`endif
        .dz_o     (dz_s),
        .res_hi_o (res_hi_s),
        .res_lo_o (res_lo_s)
    );

    // Sequencing FSM with HI/LO ownership and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        // start wins over a same-cycle MTHI/MTLO
                        cnt_q      <= {CNT_W{1'b0}};
                        div_zero_q <= dz_s;
                        busy_q     <= 1'b1;
                        state_q    <= dz_s ? FIX : CALC;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_s) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi_s;
                    lo_q    <= res_lo_s;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.stall    = busy_q & (bus.start | bus.hi_we | bus.lo_we |
                                    bus.hi_re | bus.lo_re);

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
// Self-checking bench for mdu_sequencer (default build, fixed latency).
// Directed cases plus randomized operations compared against an arithmetic
// reference model; HI/LO expectations tracked in a shadow scoreboard.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = 64'h0;
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else r = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        eh = r[63:32];
        el = r[31:0];
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        logic [31:0] eh, el;
        int          cyc;
        bit          dz;
        model(op, a, b, eh, el);
        dz = op[1] && (b == 32'h0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0; bus.rs_val = $urandom; bus.rt_val = $urandom;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (disturb) begin
                bus.hi_re = (cyc == 3);
                bus.lo_we = (cyc == 5);
                bus.wdata = 32'h1234;
                bus.start = (cyc == 7);
                if (cyc == 7) begin bus.op = 2'b11; bus.rt_val = 32'h0; end
                #1;
                if (cyc == 3 || cyc == 5 || cyc == 7) check("stall_busy", bus.stall, 1'b1);
                else if (cyc == 4) check("stall_quiet", bus.stall, 1'b0);
            end
            @(negedge clk);
        end
        bus.hi_re = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
        check("busy_cycles", cyc, dz ? 1 : 33);
        check("done", bus.done, 1'b1);
        check("hi", bus.hi, eh);
        check("lo", bus.lo, el);
        check("div_zero", bus.div_zero, dz);
        exp_hi = eh;
        exp_lo = el;
        bus.lo_re = 1'b1;
        #1;
        check("stall_done_cycle", bus.stall, 1'b0);
        bus.lo_re = 1'b0;
        @(negedge clk);
        check("done_pulse", bus.done, 1'b0);
    endtask

    task automatic mt(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we = h; bus.lo_we = l; bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        check("mt_hi", bus.hi, exp_hi);
        check("mt_lo", bus.lo, exp_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = 32'h0; bus.rt_val = 32'h0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
        bus.hi_re = 1'b0; bus.lo_re = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_dz", bus.div_zero, 1'b0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        bus.hi_re = 1'b1; bus.start = 1'b1;
        #1;
        check("rst_stall", bus.stall, 1'b0);
        bus.hi_re = 1'b0; bus.start = 1'b0;
        rst_n = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1);
        mt(1'b0, 1'b1, 32'h1234);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 1'b0);

        // reset in the middle of CALC (counter 10) aborts without commit
        mt(1'b1, 1'b1, 32'hA5A5_5A5A);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd12345; bus.rt_val = 32'd678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        mt(1'b1, 1'b0, 32'hDEAD_BEEF);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, 1'b0);
            if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, 1'b1, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit with its own sequencing FSM. It owns the HI/LO register pair used by MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Sits beside the ALU in the unicycle core.
- Raises `stall` to freeze PC and register-file writes whenever an instruction touches HI/LO while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk       input   1      system clock, rising edge
- rst_n     input   1      asynchronous active-low reset
- start     input   1      issue request for op; sampled on clk edge
- op        input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val    input   WIDTH  multiplicand / dividend
- rt_val    input   WIDTH  multiplier / divisor
- hi_we     input   1      MTHI write strobe
- lo_we     input   1      MTLO write strobe
- wdata     input   WIDTH  MTHI/MTLO data
- hi_re     input   1      MFHI in decode
- lo_re     input   1      MFLO in decode
- hi        output  WIDTH  HI register
- lo        output  WIDTH  LO register
- busy      output  1      FSM not in IDLE
- stall     output  1      busy & (start | hi_we | lo_we | hi_re | lo_re)
- done      output  1      one-cycle pulse after results commit
- div_zero  output  1      sticky: last DIV/DIVU had rt_val==0; cleared by next start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi, lo, counter, internal accumulators = 0.
  - busy=0, stall=0, done=0, div_zero=0.
  - Asserting reset mid-operation aborts it with no partial commit.
- States: IDLE, CALC, FIX.
- Issue. In IDLE, edge E0 with start=1:
  - Latch op.
  - Signed ops (MULT, DIV) latch |rs_val| and |rt_val| plus sign bits sa, sb.
  - Unsigned ops latch raw values.
  - Clear counter and div_zero.
  - Next state is CALC, except divide with rt_val==0, which goes to FIX with div_zero set.
- CALC, one iteration per cycle, counter 0..WIDTH-1:
  - MUL: shift-add; if multiplier LSB set, add multiplicand to the upper half of a 2*WIDTH accumulator, then shift right by 1.
  - DIV: restoring; shift remainder:quotient left 1; trial-subtract divisor; set quotient bit if no borrow.
  - When counter==WIDTH-1, next state is FIX.
- FIX, one cycle:
  - MULT: negate the 2*WIDTH product if sa^sb.
  - DIV: negate quotient if sa^sb; negate remainder if sa.
  - Commit on the exiting edge: MUL gives hi=product[2W-1:W], lo=product[W-1:0]; DIV gives lo=quotient, hi=remainder.
  - Next state is IDLE; done=1 during the following cycle only.
- Divide by zero: commit lo={WIDTH{1'b1}}, hi=original rs_val; no trap is raised.
- Overflow case: DIV with 0x80000000 / 0xFFFFFFFF commits lo=0x80000000, hi=0, with no flag.
- Latency:
  - Normal op: busy for WIDTH+1 cycles (E0..E(WIDTH+1)).
  - Divide by zero: busy for 1 cycle.
  - Results are visible on hi/lo in the done cycle.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we update hi/lo from wdata on the edge.
  - While busy they assert stall and are ignored; the core holds the instruction and retries.
- Start and write in the same IDLE cycle: start wins and the write is dropped. This is an illegal combination from a single-issue core, so it is a bench assertion, not functional.
- start while busy: the request is ignored, stall=1, the in-flight operation continues.
- hi_re/lo_re while busy: stall=1. In IDLE, including the done cycle, there is no stall and hi/lo are already final.
- Output timing: stall is combinational from the inputs and busy; all other outputs are registered.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined: during MUL/MULTU in CALC, when the remaining multiplier bits are all zero, finish the remaining shifts in one step and jump to FIX. Latency becomes (index of highest set multiplier-magnitude bit)+2 cycles. A zero multiplier takes 2 cycles. Division is unchanged.
- Undefined: every operation takes fixed WIDTH+1 cycles. The cycle-exact tests below assume this build.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
  - state enum IDLE/CALC/FIX.
  - DIV0_LO constant = all ones.
- One natural sub-module, mdu_datapath: accumulator/remainder registers, adder/subtractor, shifter, sign fix-up. The FSM, counter, HI/LO and stall logic stay in mdu_sequencer.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy 33 cycles, hi=0xFFFFFFFE, lo=0x00000001, done single pulse.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> busy 1 cycle, div_zero=1, lo=0xFFFFFFFF, hi=100. Next DIVU 100/7 -> div_zero=0, lo=14, hi=2.
- During MULT, pulse hi_re, lo_we=1 (wdata=0x1234) and start -> stall=1 each cycle, no corruption. After done, MTLO 0x1234 -> lo=0x1234.
- Deassert rst_n at CALC counter=10 -> hi=lo=0, busy=0 immediately. After release, DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- With MDU_EARLY_TERM_EN: MULTU 5 x 3 -> hi=0, lo=15, busy 3 cycles. MULTU 5 x 0 -> busy 2 cycles, hi=lo=0.
